// File: rtl/irq_controller_if.sv
// Register bus shared with the system timer: address/data/strobes plus registered read data.
interface irq_controller_if;
    logic [31:0] address;
    logic [31:0] data_in;
    logic        wr;
    logic        rd;
    logic [31:0] data_out;

    modport master (output address, output data_in, output wr, output rd, input data_out);
    modport slave  (input address, input data_in, input wr, input rd, output data_out);
endinterface

// File: rtl/irq_controller.sv
// Interrupt controller: latches rising edges of the source lines, masks and prioritises them,
// and raises a single request with the in-service source index to the core.
//
// state   | meaning
// IDLE    | no request; arbitrate the active sources each cycle
// ACTIVE  | irq=1 for the latched irq_id until it is acked, masked or globally disabled
// RECOVER | one forced low cycle of irq; re-arbitrates so the next request follows at once
module irq_controller #(
    parameter int          NUM_SOURCES  = 8,
    parameter logic [31:0] MASK_ADDR    = 32'h80000010,
    parameter logic [31:0] PENDING_ADDR = 32'h80000011,
    parameter logic [31:0] ACK_ADDR     = 32'h80000012,
    parameter logic [31:0] ENABLE_ADDR  = 32'h80000013
) (
    input  logic                   clk,
    input  logic                   reset,
    irq_controller_if.slave        bus,
    input  logic [NUM_SOURCES-1:0] irq_sources,
    output logic                   irq,
    output logic [4:0]             irq_id
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACTIVE  = 2'd1;
    localparam logic [1:0] RECOVER = 2'd2;

    logic [1:0]             state, state_nx;
    logic [4:0]             id_nx;
    logic [NUM_SOURCES-1:0] src_q;
    logic [NUM_SOURCES-1:0] pending, pending_nx;
    logic [NUM_SOURCES-1:0] mask, mask_nx;
    logic                   global_en, en_nx;
    logic [NUM_SOURCES-1:0] edge_v, ack_v, active;
    logic [4:0]             win_id;
    logic                   keep;
    logic [31:0]            pend_w, mask_w, rd_data;

    always_comb begin
        edge_v = irq_sources & ~src_q;
        ack_v  = '0;
        if (bus.wr && bus.address == ACK_ADDR)
            ack_v = bus.data_in[NUM_SOURCES-1:0];
        // A new edge overrides an ack of the same bit.
        pending_nx = (pending & ~ack_v) | edge_v;

        mask_nx = mask;
        if (bus.wr && bus.address == MASK_ADDR)
            mask_nx = bus.data_in[NUM_SOURCES-1:0];
        en_nx = global_en;
        if (bus.wr && bus.address == ENABLE_ADDR)
            en_nx = bus.data_in[0];

        active = global_en ? (pending & mask) : '0;
        win_id = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--)
            if (active[i])
                win_id = 5'(i);

        // Exit is judged on the post-write values so irq drops the cycle after the ack/mask write.
        pend_w = '0;
        pend_w[NUM_SOURCES-1:0] = pending_nx;
        mask_w = '0;
        mask_w[NUM_SOURCES-1:0] = mask_nx;
        keep = pend_w[irq_id] & mask_w[irq_id] & en_nx;

        state_nx = state;
        id_nx    = irq_id;
        case (state)
            IDLE, RECOVER: begin
                state_nx = IDLE;
                if (active != '0) begin
                    state_nx = ACTIVE;
                    id_nx    = win_id;
                end
            end
            ACTIVE: begin
                if (!keep)
                    state_nx = RECOVER;
            end
            default: state_nx = IDLE;
        endcase

        rd_data = '0;
        if (bus.address == MASK_ADDR)
            rd_data[NUM_SOURCES-1:0] = mask;
        else if (bus.address == PENDING_ADDR)
            rd_data[NUM_SOURCES-1:0] = pending;
        else if (bus.address == ENABLE_ADDR)
            rd_data[0] = global_en;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            irq_id       <= '0;
            src_q        <= '0;
            pending      <= '0;
            mask         <= '0;
            global_en    <= 1'b0;
            bus.data_out <= '0;
        end else begin
            state     <= state_nx;
            irq_id    <= id_nx;
            src_q     <= irq_sources;
            pending   <= pending_nx;
            mask      <= mask_nx;
            global_en <= en_nx;
            if (bus.rd)
                bus.data_out <= rd_data;
        end
    end

    assign irq = (state == ACTIVE);

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with a per-cycle reference model of the
// register file and the request/ID behaviour.
module tb_irq_controller;

    localparam logic [31:0] MASK_A = 32'h80000010;
    localparam logic [31:0] PEND_A = 32'h80000011;
    localparam logic [31:0] ACK_A  = 32'h80000012;
    localparam logic [31:0] EN_A   = 32'h80000013;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] irq_sources = '0;
    logic       irq;
    logic [4:0] irq_id;

    int tests = 0;
    int fails = 0;

    irq_controller_if bus ();

    irq_controller #(.NUM_SOURCES(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .irq_sources (irq_sources),
        .irq         (irq),
        .irq_id      (irq_id)
    );

    always #5 clk = ~clk;

    // Reference model: registers as the software sees them, plus "is a source being serviced".
    logic [7:0]  m_mask, m_pend, m_srcq;
    logic        m_en, m_svc;
    logic [4:0]  m_id;
    logic [31:0] m_dout;

    logic [7:0]  c_edge, c_ack, c_pend, c_mask, c_act;
    logic        c_en, c_drop, c_any;
    logic [4:0]  c_low;
    logic [31:0] c_dout;

    always_comb begin
        c_edge = irq_sources & ~m_srcq;
        c_ack  = (bus.wr && bus.address == ACK_A) ? bus.data_in[7:0] : 8'h00;
        c_pend = (m_pend & ~c_ack) | c_edge;
        c_mask = (bus.wr && bus.address == MASK_A) ? bus.data_in[7:0] : m_mask;
        c_en   = (bus.wr && bus.address == EN_A) ? bus.data_in[0] : m_en;
        c_act  = m_en ? (m_pend & m_mask) : 8'h00;
        c_any  = (c_act != 8'h00);
        c_low  = 5'd0;
        for (int i = 7; i >= 0; i--)
            if (c_act[i]) c_low = 5'(i);
        c_drop = !(c_pend[m_id[2:0]] && c_mask[m_id[2:0]] && c_en);
        c_dout = m_dout;
        if (bus.rd) begin
            if (bus.address == MASK_A)      c_dout = {24'h0, m_mask};
            else if (bus.address == PEND_A) c_dout = {24'h0, m_pend};
            else if (bus.address == EN_A)   c_dout = {31'h0, m_en};
            else                            c_dout = 32'h0;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mask <= '0; m_pend <= '0; m_srcq <= '0; m_en <= 1'b0;
            m_svc  <= 1'b0; m_id <= '0; m_dout <= '0;
        end else begin
            m_mask <= c_mask; m_pend <= c_pend; m_srcq <= irq_sources; m_en <= c_en;
            m_dout <= c_dout;
            if (m_svc) begin
                if (c_drop) m_svc <= 1'b0;
            end else if (c_any) begin
                m_svc <= 1'b1;
                m_id  <= c_low;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_irq", {31'h0, irq}, {31'h0, m_svc});
        check("model_irq_id", {27'h0, irq_id}, {27'h0, m_id});
        check("model_data_out", bus.data_out, m_dout);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        bus.address = a; bus.data_in = d; bus.wr = 1'b1;
        @(negedge clk);
        bus.wr = 1'b0;
    endtask

    task automatic bus_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus.address = a; bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
        check(name, bus.data_out, exp);
    endtask

    task automatic pulse(input logic [7:0] v);
        irq_sources = v;
        @(negedge clk);
        irq_sources = 8'h00;
    endtask

    task automatic chk_irq(input string name, input logic e_irq, input logic [4:0] e_id);
        check({name, "_irq"}, {31'h0, irq}, {31'h0, e_irq});
        if (e_irq) check({name, "_id"}, {27'h0, irq_id}, {27'h0, e_id});
    endtask

    initial begin
        bus.address = '0; bus.data_in = '0; bus.wr = 1'b0; bus.rd = 1'b0;
        tick(2);
        reset = 1'b0;
        chk_irq("reset", 1'b0, 5'd0);
        check("reset_id", {27'h0, irq_id}, 32'h0);
        check("reset_dout", bus.data_out, 32'h0);

        // Timer source: pending after one edge, irq after two, ack drops it next cycle.
        bus_wr(EN_A, 32'h1);
        bus_wr(MASK_A, 32'h1);
        pulse(8'h01);
        chk_irq("t1_lat1", 1'b0, 5'd0);
        tick(1);
        chk_irq("t1_lat2", 1'b1, 5'd0);
        bus_rd("t1_pend", PEND_A, 32'h01);
        bus_wr(ACK_A, 32'h1);
        chk_irq("t1_ack", 1'b0, 5'd0);
        bus_rd("t1_pend_clr", PEND_A, 32'h00);

        // Masked source stays pending, fires once unmasked.
        bus_wr(MASK_A, 32'h0);
        pulse(8'h08);
        bus_rd("t2_pend", PEND_A, 32'h08);
        chk_irq("t2_masked", 1'b0, 5'd0);
        bus_wr(MASK_A, 32'h08);
        chk_irq("t2_unmask0", 1'b0, 5'd0);
        tick(1);
        chk_irq("t2_unmask1", 1'b1, 5'd3);
        bus_wr(ACK_A, 32'h08);
        tick(2);

        // Simultaneous edges: lowest index wins; one low cycle between requests.
        bus_wr(MASK_A, 32'hFF);
        pulse(8'h24);
        tick(1);
        chk_irq("t3_win", 1'b1, 5'd2);
        bus_wr(ACK_A, 32'h04);
        chk_irq("t3_gap", 1'b0, 5'd0);
        tick(1);
        chk_irq("t3_next", 1'b1, 5'd5);

        // Higher priority arrival does not preempt.
        pulse(8'h01);
        chk_irq("t4_hold0", 1'b1, 5'd5);
        tick(1);
        chk_irq("t4_hold1", 1'b1, 5'd5);
        bus_wr(ACK_A, 32'h20);
        chk_irq("t4_gap", 1'b0, 5'd0);
        tick(1);
        chk_irq("t4_next", 1'b1, 5'd0);
        bus_wr(ACK_A, 32'h01);
        tick(2);

        // Held level sets pending once; edge coincident with ack keeps the bit.
        irq_sources = 8'h02;
        tick(3);
        bus_wr(ACK_A, 32'h02);
        tick(5);
        bus_rd("t5_level", PEND_A, 32'h00);
        irq_sources = 8'h00;
        tick(1);
        pulse(8'h02);
        tick(2);
        chk_irq("t5_svc", 1'b1, 5'd1);
        bus.address = ACK_A; bus.data_in = 32'h02; bus.wr = 1'b1; irq_sources = 8'h02;
        @(negedge clk);
        bus.wr = 1'b0;
        bus_rd("t5_setwins", PEND_A, 32'h02);
        irq_sources = 8'h00;
        chk_irq("t5_still", 1'b1, 5'd1);
        bus_rd("ack_reads0", ACK_A, 32'h0);
        bus_rd("en_read", EN_A, 32'h1);

        // Reset while servicing clears everything at once.
        chk_irq("t6_pre", 1'b1, 5'd1);
        reset = 1'b1;
        #1;
        check("t6_irq", {31'h0, irq}, 32'h0);
        check("t6_id", {27'h0, irq_id}, 32'h0);
        check("t6_dout", bus.data_out, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        bus_rd("t6_en", EN_A, 32'h0);
        bus_rd("t6_mask", MASK_A, 32'h0);
        bus_rd("t6_pend", PEND_A, 32'h0);

        // Read-during-write, read-only and unmapped writes, upper data bits ignored.
        bus_wr(MASK_A, 32'h33);
        bus.address = MASK_A; bus.data_in = 32'h5A; bus.wr = 1'b1; bus.rd = 1'b1;
        @(negedge clk);
        bus.wr = 1'b0; bus.rd = 1'b0;
        check("rdwr_old", bus.data_out, 32'h33);
        bus_rd("rdwr_new", MASK_A, 32'h5A);
        bus_wr(PEND_A, 32'hFF);
        bus_rd("pend_ro", PEND_A, 32'h0);
        bus_wr(32'h80000020, 32'hFF);
        bus_rd("unmapped", MASK_A, 32'h5A);
        bus_wr(MASK_A, 32'hFFFFFF00);
        bus_rd("mask_upper", MASK_A, 32'h0);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
